// File: rtl/alu.sv
// Registered MIPS ALU: eight operations on LENGTH-bit operands.
// Result is captured every clock; async active-low reset clears it.
module alu #(
  parameter int LENGTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        ALU_Sel,
  input  logic [LENGTH-1:0] A,
  input  logic [LENGTH-1:0] B,
  input  logic [4:0]        shamt,
  output logic [LENGTH-1:0] ALU_Out
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SLL = 3'b011;
  localparam logic [2:0] OP_SRL = 3'b100;
  localparam logic [2:0] OP_NOR = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic [LENGTH-1:0] r;
  logic [31:0]       sh_ext;
  logic              sh_big;
  logic              lt;

  assign sh_ext = {27'b0, shamt};
  // Only reachable when LENGTH <= 31; shifting past the width yields 0.
  assign sh_big = (sh_ext >= 32'(LENGTH));
  // True signed compare, immune to A-B overflow.
  assign lt     = ($signed(A) < $signed(B));

  always_comb begin
    r = '0;
    unique case (ALU_Sel)
      OP_AND: r = A & B;
      OP_OR:  r = A | B;
      OP_ADD: r = A + B;
      OP_SLL: r = sh_big ? '0 : (B << shamt);
      OP_SRL: r = sh_big ? '0 : (B >> shamt);
      OP_NOR: r = ~(A | B);
      OP_SUB: r = A - B;
      OP_SLT: r = {{(LENGTH-1){1'b0}}, lt};
      default: r = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ALU_Out <= '0;
    else        ALU_Out <= r;
  end

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu: table of operations plus
// hand-written reset, latency and narrow-width shift sequences.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [2:0]  sel;
  logic [31:0] a, b;
  logic [4:0]  sh;
  logic [31:0] out;
  logic [7:0]  a8, b8;
  logic [7:0]  out8;

  int n_vec;
  int n_err;

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  alu #(.LENGTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .ALU_Sel(sel),
    .A(a), .B(b), .shamt(sh), .ALU_Out(out)
  );

  alu #(.LENGTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .ALU_Sel(sel),
    .A(a8), .B(b8), .shamt(sh), .ALU_Out(out8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] s,
                       input logic [31:0] va,
                       input logic [31:0] vb,
                       input logic [4:0] vs);
    sel = s; a = va; b = vb; sh = vs;
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] prev;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b1;
    drive(3'b010, 32'd0, 32'd0, 5'd0);
    a8 = 8'h00;
    b8 = 8'h00;

    vecs.push_back('{3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hF000F000});
    vecs.push_back('{3'b001, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hFFF0FFF0});
    vecs.push_back('{3'b101, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'h000F000F});
    vecs.push_back('{3'b010, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000000});
    vecs.push_back('{3'b110, 32'h00000000, 32'h00000001, 5'd0, 32'hFFFFFFFF});
    vecs.push_back('{3'b110, 32'h00000005, 32'h00000003, 5'd0, 32'h00000002});
    vecs.push_back('{3'b011, 32'h12345678, 32'h80000001, 5'd1, 32'h00000002});
    vecs.push_back('{3'b100, 32'hFFFFFFFF, 32'h80000001, 5'd31, 32'h00000001});
    vecs.push_back('{3'b100, 32'hFFFFFFFF, 32'h80000001, 5'd0, 32'h80000001});
    vecs.push_back('{3'b011, 32'h0, 32'h80000001, 5'd31, 32'h80000000});
    vecs.push_back('{3'b011, 32'h0, 32'h0000000F, 5'd4, 32'h000000F0});
    vecs.push_back('{3'b111, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000001});
    vecs.push_back('{3'b111, 32'h00000001, 32'hFFFFFFFF, 5'd0, 32'h00000000});
    vecs.push_back('{3'b111, 32'h80000000, 32'h7FFFFFFF, 5'd0, 32'h00000001});
    vecs.push_back('{3'b111, 32'h7FFFFFFF, 32'h80000000, 5'd0, 32'h00000000});
    vecs.push_back('{3'b111, 32'h00000007, 32'h00000007, 5'd0, 32'h00000000});
    vecs.push_back('{3'b010, 32'h7FFFFFFF, 32'h00000001, 5'd0, 32'h80000000});

    // Asynchronous reset with no clock edge
    #1 rst_n = 1'b0;
    #1 chk("reset_no_clk", out, 32'h0);
    edge_sample();
    edge_sample();
    chk("reset_hold", out, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    drive(3'b010, 32'h1, 32'h2, 5'd1);
    #1 chk("pre_first_edge", out, 32'h0);
    edge_sample();
    chk("add_first", out, 32'h3);
    edge_sample();
    edge_sample();
    chk("add_hold", out, 32'h3);

    prev = 32'h3;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].sh);
      #1 chk($sformatf("latency[%0d]", i), out, prev);
      edge_sample();
      chk($sformatf("vec[%0d]", i), out, vecs[i].exp);
      prev = vecs[i].exp;
    end

    // Narrow instance: shift counts at or past the width
    @(negedge clk);
    drive(3'b011, 32'h0, 32'h0, 5'd8);
    b8 = 8'hFF;
    edge_sample();
    chk("w8_sll_8", {24'h0, out8}, 32'h0);
    @(negedge clk);
    drive(3'b100, 32'h0, 32'h0, 5'd9);
    edge_sample();
    chk("w8_srl_9", {24'h0, out8}, 32'h0);
    @(negedge clk);
    drive(3'b011, 32'h0, 32'h0, 5'd7);
    b8 = 8'h01;
    edge_sample();
    chk("w8_sll_7", {24'h0, out8}, 32'h80);
    @(negedge clk);
    drive(3'b100, 32'h0, 32'h0, 5'd7);
    b8 = 8'h80;
    edge_sample();
    chk("w8_srl_7", {24'h0, out8}, 32'h01);

    // Reset pulled mid-stream between edges
    @(negedge clk);
    drive(3'b010, 32'h1, 32'h2, 5'd0);
    edge_sample();
    chk("mid_add", out, 32'h3);
    #2 rst_n = 1'b0;
    #1 chk("mid_reset_now", out, 32'h0);
    edge_sample();
    chk("mid_reset_hold", out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("mid_release", out, 32'h0);
    edge_sample();
    chk("mid_recover", out, 32'h3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu.md
# alu

Registered arithmetic/logic unit for the MIPS datapath. Each rising clock edge it computes one of eight operations on two `LENGTH`-bit operands, selected by a 3-bit code from the control FSM, and registers the result. Shift operations use a separate 5-bit shift amount taken from the instruction's `shamt` field.

## Interface
Parameters:
- `LENGTH`, default 32: operand and result width in bits; must be ≥ 2.

Ports:
- `clk` — input, 1 — system clock; rising edge active.
- `rst_n` — input, 1 — reset, asynchronous, active-low.
- `ALU_Sel` — input, 3 — operation select.
- `A` — input, `LENGTH` — operand A (rs).
- `B` — input, `LENGTH` — operand B (rt or immediate); also the value shifted by SLL/SRL.
- `shamt` — input, 5 — shift amount, unsigned.
- `ALU_Out` — output, `LENGTH` — registered result.

One clock; reset is asynchronous and active-low.

## Operation
- Operation encoding for `ALU_Sel`:
  - 000 AND: A & B.
  - 001 OR: A | B.
  - 010 ADD: A + B, modulo 2^LENGTH. Carry and overflow are discarded.
  - 011 SLL: B << shamt, zero fill.
  - 100 SRL: B >> shamt, logical, zero fill.
  - 101 NOR: ~(A | B).
  - 110 SUB: A − B, modulo 2^LENGTH, two's complement.
  - 111 SLT: result is 1 if A < B as signed two's complement, else 0.
- SLT must use a proper signed compare. The sign of A−B alone is not sufficient, because the subtraction can overflow.
- Shift count:
  - `shamt` is zero-extended.
  - If `shamt` ≥ `LENGTH`, SLL and SRL produce 0.
  - `shamt` = 0 passes B unchanged.
- A and B are ignored by operations that do not use them. SLL and SRL ignore A.
- No flags or status outputs are produced.

## Timing
- Combinational result `r = f(ALU_Sel, A, B, shamt)` is captured into `ALU_Out` on every rising `clk`.
- `ALU_Out` is updated every cycle; there is no enable.
- Latency: inputs stable before edge N produce the result on `ALU_Out` after edge N. This is 1-cycle latency, with no handshake.
- Reset:
  - `rst_n` low clears `ALU_Out` to 0 immediately, asynchronously and independent of `clk`.
  - `ALU_Out` is held at 0 while `rst_n` is low.
  - The first capture happens at the first rising `clk` after `rst_n` deasserts.
- Mid-operation reset: the in-flight result is lost and the output reads 0. No recovery state exists.
- Input changes between edges do not affect `ALU_Out` until the next edge. The output is glitch-free because it comes straight from a flop.

## Test plan
1. Reset, then add:
   - Assert `rst_n`=0 → `ALU_Out`=0 without any clock edge.
   - Release reset, apply A=0x00000001, B=0x00000002, `ALU_Sel`=010, `shamt`=1 → `ALU_Out`=0x00000003 after the next rising edge, and it stays 3 on every later edge.
2. Logic ops with A=0xF0F0F0F0, B=0xFF00FF00:
   - AND → 0xF000F000.
   - OR → 0xFFF0FFF0.
   - NOR → 0x000F000F.
   - Each result appears one edge after `ALU_Sel` changes.
3. Arithmetic wrap:
   - ADD, A=0xFFFFFFFF, B=1 → 0x00000000.
   - SUB, A=0, B=1 → 0xFFFFFFFF.
   - SUB, A=5, B=3 → 0x00000002.
4. Shifts with B=0x80000001:
   - SLL, `shamt`=1 → 0x00000002.
   - SRL, `shamt`=31 → 0x00000001.
   - SRL, `shamt`=0 → 0x80000001.
5. SLT:
   - A=0xFFFFFFFF (−1), B=1 → 1.
   - A=1, B=0xFFFFFFFF → 0.
   - A=0x80000000, B=0x7FFFFFFF → 1 (overflow case).
   - A=B=7 → 0.
6. Asynchronous reset mid-stream:
   - While running ADD producing 3, pull `rst_n` low between clock edges → `ALU_Out`=0 immediately.
   - It stays 0 while low, then becomes 3 at the first rising edge after release.
